// File: rtl/controlador_display_pkg.sv
// rtl/controlador_display_pkg.sv - shared segment patterns, FSM states and BCD step helper
package controlador_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } estado_t;

  function automatic logic [6:0] codifica_digito(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One shift-add-3 step over {14-bit BCD, 10-bit binary}; the top BCD digit
  // can only reach 1, so it never needs correcting.
  function automatic logic [23:0] paso_doble_dabble(input logic [23:0] r);
    logic [23:0] t;
    t = r;
    for (int k = 0; k < 3; k++) begin
      if (t[10+4*k +: 4] >= 4'd5) t[10+4*k +: 4] = t[10+4*k +: 4] + 4'd3;
    end
    return {t[22:0], 1'b0};
  endfunction

endpackage

// File: rtl/controlador_display_conversor.sv
// rtl/controlador_display_conversor.sv - sequential 10-bit binary to BCD converter
module conversor_bin_bcd
  import controlador_display_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [9:0]  bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  estado_t     estado_q, estado_d;
  logic [9:0]  bin_q, bin_d;
  logic [23:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      estado_q <= IDLE;
      bin_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      bin_q    <= bin_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    bin_d    = bin_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    case (estado_q)
      IDLE: begin
        if (start_i) begin
          bin_d    = bin_i;
          estado_d = LOAD;
        end
      end
      LOAD: begin
        sr_d     = {14'd0, bin_q};
        cnt_d    = '0;
        estado_d = SHIFT;
      end
      SHIFT: begin
        sr_d  = paso_doble_dabble(sr_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) estado_d = DONE;
      end
      DONE:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  assign busy_o = (estado_q != IDLE);
  assign done_o = (estado_q == DONE);
  assign bcd_o  = {2'b00, sr_q[23:10]};

endmodule

// File: rtl/controlador_display.sv
// rtl/controlador_display.sv - 4-digit multiplexed 7-segment driver for frequency/current
module controlador_display
  import controlador_display_pkg::*;
#(
  parameter logic [15:0] DIV_REFRESCO = 16'd50000
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic [7:0] frecuencia,
  input  logic [9:0] corriente,
  input  logic       control,
  output logic [6:0] codificacion,
  output logic [3:0] digito
);

  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic        first_q;
  logic [15:0] disp_q, disp_d;
  logic [6:0]  cod_q, cod_d;
  logic [3:0]  dig_q, dig_d;

  logic        tick, start, busy, done;
  logic [15:0] bcd;
  logic [9:0]  valor_sel;
  logic [3:0]  blank;
  logic [3:0]  nibble;

  assign tick      = (presc_q == DIV_REFRESCO - 16'd1);
  assign start     = (first_q | (tick & (idx_q == 2'd3))) & ~busy;
  assign valor_sel = control ? {2'b00, frecuencia} : corriente;

  conversor_bin_bcd u_conversor (
    .clk_i   (clk_d),
    .reset_i (reset),
    .start_i (start),
    .bin_i   (valor_sel),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  // A digit is blanked only when it and every higher digit are zero.
  assign blank[3] = (disp_q[15:12] == 4'd0);
  assign blank[2] = blank[3] & (disp_q[11:8] == 4'd0);
  assign blank[1] = blank[2] & (disp_q[7:4] == 4'd0);
  assign blank[0] = 1'b0;

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    disp_d  = done ? bcd : disp_q;
    nibble  = disp_q[idx_q*4 +: 4];
    cod_d   = blank[idx_q] ? SEG_BLANK : codifica_digito(nibble);
    dig_d   = 4'b0001 << idx_q;
  end

  always_ff @(posedge clk_d) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      disp_q  <= '0;
      cod_q   <= SEG_BLANK;
      dig_q   <= 4'b0001;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      disp_q  <= disp_d;
      cod_q   <= cod_d;
      dig_q   <= dig_d;
    end
  end

  assign codificacion = cod_q;
  assign digito       = dig_q;

endmodule

// File: tb/tb_controlador_display.sv
// tb/tb_controlador_display.sv - self-checking bench for controlador_display
module tb_controlador_display;

  localparam int DIV   = 16;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100, PB = 7'b1111111;

  logic       clk_d = 1'b0;
  logic       reset;
  logic [7:0] frecuencia;
  logic [9:0] corriente;
  logic       control;
  logic [6:0] codificacion;
  logic [3:0] digito;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        ctl;
    logic [7:0]  frec;
    logic [9:0]  corr;
    logic [27:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [10];

  controlador_display #(.DIV_REFRESCO(16'(DIV))) dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .frecuencia   (frecuencia),
    .corriente    (corriente),
    .control      (control),
    .codificacion (codificacion),
    .digito       (digito)
  );

  always #5 clk_d = ~clk_d;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_dig(input logic [3:0] want, input string nm);
    int n = 0;
    while (digito !== want && n < 300) begin
      @(negedge clk_d);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting digito %b", nm, want);
    end
  endtask

  task automatic scan_frame(output logic [27:0] got, output int bad_sel);
    got = '0;
    bad_sel = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk_d);
      case (digito)
        4'b0001: got[6:0]   = codificacion;
        4'b0010: got[13:7]  = codificacion;
        4'b0100: got[20:14] = codificacion;
        4'b1000: got[27:21] = codificacion;
        default: bad_sel++;
      endcase
    end
  endtask

  task automatic check_frame(input string nm, input logic [27:0] exp);
    logic [27:0] got;
    int bs;
    scan_frame(got, bs);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s_d%0d", nm, d), 32'(got[7*d +: 7]), 32'(exp[7*d +: 7]));
    check($sformatf("%s_onehot", nm), bs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] exp500;
    int hold_bad;
    int n;

    vecs[0] = '{1'b1, 8'd75,  10'd0,    {PB, PB, P7, P5}};
    vecs[1] = '{1'b0, 8'd0,   10'd1000, {P1, P0, P0, P0}};
    vecs[2] = '{1'b0, 8'd0,   10'd1023, {P1, P0, P2, P3}};
    vecs[3] = '{1'b0, 8'd75,  10'd0,    {PB, PB, PB, P0}};
    vecs[4] = '{1'b1, 8'd255, 10'd3,    {PB, P2, P5, P5}};
    vecs[5] = '{1'b0, 8'd1,   10'd100,  {PB, P1, P0, P0}};
    vecs[6] = '{1'b0, 8'd0,   10'd509,  {PB, P5, P0, P9}};
    vecs[7] = '{1'b1, 8'd8,   10'd999,  {PB, PB, PB, P8}};
    vecs[8] = '{1'b0, 8'd8,   10'd999,  {PB, P9, P9, P9}};
    vecs[9] = '{1'b0, 8'd0,   10'd64,   {PB, PB, P6, P4}};
    exp500  = {PB, P5, P0, P0};

    reset = 1'b1; control = 1'b0; frecuencia = '0; corriente = '0;
    repeat (3) @(negedge clk_d);
    check("rst_cod", 32'(codificacion), 32'(PB));
    check("rst_dig", 32'(digito), 32'h1);
    reset = 1'b0;
    @(negedge clk_d);
    check("post_rst_cod", 32'(codificacion), 32'(P0));
    check("post_rst_dig", 32'(digito), 32'h1);
    repeat (12) @(negedge clk_d);
    check_frame("boot", {PB, PB, PB, P0});

    for (int i = 0; i < 10; i++) begin
      control = vecs[i].ctl; frecuencia = vecs[i].frec; corriente = vecs[i].corr;
      repeat (2 * FRAME) @(negedge clk_d);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Source toggled mid-frame must not disturb the frame already on screen.
    control = 1'b0; frecuencia = 8'd30; corriente = 10'd500;
    repeat (2 * FRAME) @(negedge clk_d);
    wait_dig(4'b0010, "tog_wait1");
    control = 1'b1;
    hold_bad = 0;
    n = 0;
    while (digito !== 4'b0001 && n < 300) begin
      case (digito)
        4'b0010: if (codificacion !== exp500[13:7])  hold_bad++;
        4'b0100: if (codificacion !== exp500[20:14]) hold_bad++;
        4'b1000: if (codificacion !== exp500[27:21]) hold_bad++;
        default: hold_bad++;
      endcase
      @(negedge clk_d);
      n++;
    end
    check("tog_hold", hold_bad, 0);
    check("tog_wrap_seen", 32'(digito), 32'h1);
    repeat (14) @(negedge clk_d);
    check_frame("tog_new", {PB, PB, P3, P0});

    // Exact display latency relative to the 3->0 wrap.
    control = 1'b0; corriente = 10'd7;
    repeat (2 * FRAME) @(negedge clk_d);
    wait_dig(4'b0010, "lat_wait1");
    corriente = 10'd8;
    wait_dig(4'b0001, "lat_wait2");
    repeat (11) @(negedge clk_d);
    check("lat_k11_old", 32'(codificacion), 32'(P7));
    @(negedge clk_d);
    check("lat_k12_new", 32'(codificacion), 32'(P8));

    // Reset during SHIFT aborts the conversion and clears the display.
    corriente = 10'd1023;
    repeat (2 * FRAME) @(negedge clk_d);
    wait_dig(4'b0010, "rs_wait1");
    corriente = 10'd75;
    wait_dig(4'b0001, "rs_wait2");
    repeat (3) @(negedge clk_d);
    reset = 1'b1;
    @(negedge clk_d);
    check("rs_cod", 32'(codificacion), 32'(PB));
    check("rs_dig", 32'(digito), 32'h1);
    @(negedge clk_d);
    reset = 1'b0;
    @(negedge clk_d);
    check("rs_rel_cod", 32'(codificacion), 32'(P0));
    check("rs_rel_dig", 32'(digito), 32'h1);
    repeat (12) @(negedge clk_d);
    check("rs_k12_cleared", 32'(codificacion), 32'(P0));
    @(negedge clk_d);
    check("rs_k13_new", 32'(codificacion), 32'(P5));
    repeat (2 * FRAME) @(negedge clk_d);
    check_frame("rs_after", {PB, PB, P7, P5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
